// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mult_sequencer
//  Purpose  : Iterative 32-step shift-add multiplier for the execute stage.
//             Borrows the shared ALU (add mode) while running, applies a
//             two's-complement fixup for negative signed products, and
//             commits the 2*WIDTH-bit product to architectural HI/LO.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            : clock, rising edge
//    rst            : synchronous reset, active-low
//    start          : multiply request, honoured in IDLE or DONE only
//    sgn            : 1 = signed (mult), 0 = unsigned (multu)
//    srca, srcb     : operands, captured with start
//    alu_y          : shared ALU sum (alu_a + alu_b)
//    hi_rd, lo_rd   : an instruction wants HI/LO this cycle
//    alu_own        : this block drives the shared ALU
//    alu_a, alu_b   : ALU operands (0 when alu_own = 0)
//    busy           : product in progress
//    stall          : pipeline hold request to the hazard unit
//    done           : one-cycle pulse when hi/lo take a new product
//    hi, lo         : architectural HI/LO registers
// ============================================================================
module mult_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             hi_rd,
  input  logic             lo_rd,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_NEG_LO = 3'd2,
    S_NEG_HI = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_mcand, w_mcand_nx;
  logic [WIDTH-1:0] r_phi,   w_phi_nx;
  logic [WIDTH-1:0] r_plo,   w_plo_nx;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nx;
  logic             r_neg,   w_neg_nx;
  logic             r_c_lo,  w_c_lo_nx;
  logic [WIDTH-1:0] r_hi,    r_lo;

  logic [WIDTH-1:0] w_alu_a, w_alu_b;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic             w_carry;
  logic             w_take;

  // Operand magnitudes use a local negate so the ALU is not needed at start.
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign w_mag_a = (sgn && srca[WIDTH-1]) ? (~srca + c_one) : srca;
  assign w_mag_b = (sgn && srcb[WIDTH-1]) ? (~srcb + c_one) : srcb;

  // Carry-out of the shared adder reconstructed from its operand/sum MSBs.
  assign w_carry = (w_alu_a[WIDTH-1] & w_alu_b[WIDTH-1]) |
                   ((w_alu_a[WIDTH-1] | w_alu_b[WIDTH-1]) & ~alu_y[WIDTH-1]);

  assign w_take = start && (r_state == S_IDLE || r_state == S_DONE);

  always_comb begin
    w_state_nx = r_state;
    w_mcand_nx = r_mcand;
    w_phi_nx   = r_phi;
    w_plo_nx   = r_plo;
    w_cnt_nx   = r_cnt;
    w_neg_nx   = r_neg;
    w_c_lo_nx  = r_c_lo;
    w_alu_a    = '0;
    w_alu_b    = '0;

    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_nx = S_IDLE;
        if (w_take) begin
          w_state_nx = S_RUN;
          w_mcand_nx = w_mag_a;
          w_plo_nx   = w_mag_b;
          w_phi_nx   = '0;
          w_cnt_nx   = '0;
          w_neg_nx   = sgn & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
        end
      end

      S_RUN: begin
        w_alu_a  = r_phi;
        w_alu_b  = r_plo[0] ? r_mcand : '0;
        // 65-bit {carry, sum, plo} shifted right by one into {phi, plo}.
        w_phi_nx = {w_carry, alu_y[WIDTH-1:1]};
        w_plo_nx = {alu_y[0], r_plo[WIDTH-1:1]};
        w_cnt_nx = r_cnt + 1'b1;
        if (r_cnt == c_last) begin
          w_state_nx = r_neg ? S_NEG_LO : S_DONE;
        end
      end

      S_NEG_LO: begin
        w_alu_a    = ~r_plo;
        w_alu_b    = c_one;
        w_plo_nx   = alu_y;
        w_c_lo_nx  = w_carry;
        w_state_nx = S_NEG_HI;
      end

      S_NEG_HI: begin
        w_alu_a    = ~r_phi;
        w_alu_b    = {{(WIDTH-1){1'b0}}, r_c_lo};
        w_phi_nx   = alu_y;
        w_state_nx = S_DONE;
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_mcand <= '0;
      r_phi   <= '0;
      r_plo   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_c_lo  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_mcand <= w_mcand_nx;
      r_phi   <= w_phi_nx;
      r_plo   <= w_plo_nx;
      r_cnt   <= w_cnt_nx;
      r_neg   <= w_neg_nx;
      r_c_lo  <= w_c_lo_nx;
      // Commit the finished product as DONE is entered; DONE never
      // re-enters itself, so this fires exactly once per product.
      if (w_state_nx == S_DONE) begin
        r_hi <= w_phi_nx;
        r_lo <= w_plo_nx;
      end
    end
  end

  assign busy    = (r_state == S_RUN) || (r_state == S_NEG_LO) ||
                   (r_state == S_NEG_HI);
  assign alu_own = busy;
  assign alu_a   = w_alu_a;
  assign alu_b   = w_alu_b;
  assign done    = (r_state == S_DONE);
  assign stall   = busy & (hi_rd | lo_rd | start);
  assign hi      = r_hi;
  assign lo      = r_lo;

endmodule
`default_nettype wire
